// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit.
//   shift_op_e  : operation encoding (SLL, SRL, SRA, ROR)
//   stage_ctl_t : control part of a stage record (valid, op, operand MSB);
//                 the width-dependent fields (data, amount, tag) travel beside it.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic      valid;
    shift_op_e op;
    logic      msb;    // operand MSB captured at acceptance, used as SRA fill
  } stage_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally shifts by 2**K when amount bit K is set,
// then registers the full stage record.
//   load        : stage may capture its upstream record this cycle
//   prev_*      : upstream record (unit input for K == 0)
//   ctl_q/...   : registered record presented to the next stage
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned K     = 0,
  localparam int unsigned AMTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  stage_ctl_t       prev_ctl,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [AMTW-1:0]  prev_amt,
  input  logic [TAGW-1:0]  prev_tag,
  output stage_ctl_t       ctl_q,
  output logic [WIDTH-1:0] data_q,
  output logic [AMTW-1:0]  amt_q,
  output logic [TAGW-1:0]  tag_q
);

  localparam int unsigned STEP = 1 << K;

  logic [WIDTH-1:0] shifted;

  // Single mux level: pass-through or shift by STEP with op-specific fill.
  always_comb begin
    shifted = prev_data;
    if (prev_amt[K]) begin
      case (prev_ctl.op)
        OP_SLL: shifted = prev_data << STEP;
        OP_SRL: shifted = prev_data >> STEP;
        OP_SRA: shifted = (prev_data >> STEP) |
                          (prev_ctl.msb ? ~({WIDTH{1'b1}} >> STEP) : '0);
        OP_ROR: shifted = (prev_data >> STEP) | (prev_data << (WIDTH - STEP));
      endcase
    end
  end

  // Stage record; payload only moves when a valid record arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      data_q <= '0;
      amt_q  <= '0;
      tag_q  <= '0;
    end else if (load) begin
      ctl_q.valid <= prev_ctl.valid;
      if (prev_ctl.valid) begin
        ctl_q.op  <= prev_ctl.op;
        ctl_q.msb <= prev_ctl.msb;
        data_q    <= shifted;
        amt_q     <= prev_amt;
        tag_q     <= prev_tag;
      end
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshakes.
// AMTW = log2(WIDTH) stages, each resolving one amount bit.
//   clk, rst_n                       : clock, async active-low reset
//   in_valid/in_ready                : request handshake
//   in_data, in_amt, in_op, in_tag   : operand, amount, op, opaque tag
//   out_valid/out_ready              : result handshake
//   out_data, out_zero, out_tag      : result, result==0 flag, tag
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4,
  localparam int unsigned AMTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  stage_ctl_t       in_ctl;
  stage_ctl_t       ctl_q  [AMTW];
  logic [WIDTH-1:0] data_q [AMTW];
  logic [AMTW-1:0]  amt_q  [AMTW];
  logic [TAGW-1:0]  tag_q  [AMTW];
  logic [AMTW:0]    ready;

  assign in_ctl = '{valid: in_valid, op: shift_op_e'(in_op), msb: in_data[WIDTH-1]};

  // Stage k may load when empty or when its downstream neighbour loads/drains.
  always_comb begin
    ready[AMTW] = out_ready;
    for (int k = AMTW - 1; k >= 0; k--) begin
      ready[k] = ~ctl_q[k].valid | ready[k+1];
    end
  end

  // Stage valids are already clear in reset; rst_n still masks the request side.
  assign in_ready = rst_n & ready[0];

  for (genvar k = 0; k < AMTW; k++) begin : g_stage
    stage_ctl_t       prev_ctl;
    logic [WIDTH-1:0] prev_data;
    logic [AMTW-1:0]  prev_amt;
    logic [TAGW-1:0]  prev_tag;

    if (k == 0) begin : g_head
      assign prev_ctl  = in_ctl;
      assign prev_data = in_data;
      assign prev_amt  = in_amt;
      assign prev_tag  = in_tag;
    end else begin : g_body
      assign prev_ctl  = ctl_q[k-1];
      assign prev_data = data_q[k-1];
      assign prev_amt  = amt_q[k-1];
      assign prev_tag  = tag_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .TAGW  (TAGW),
      .K     (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ready[k]),
      .prev_ctl  (prev_ctl),
      .prev_data (prev_data),
      .prev_amt  (prev_amt),
      .prev_tag  (prev_tag),
      .ctl_q     (ctl_q[k]),
      .data_q    (data_q[k]),
      .amt_q     (amt_q[k]),
      .tag_q     (tag_q[k])
    );
  end

  assign out_valid = ctl_q[AMTW-1].valid;
  assign out_data  = data_q[AMTW-1];
  assign out_tag   = tag_q[AMTW-1];
  // Zero flag taken from the final data register.
  assign out_zero  = ~|data_q[AMTW-1];

  // Final-stage op/msb/amount have no consumer past the last stage.
  logic unused_tail;
  assign unused_tail = ^{ctl_q[AMTW-1].op, ctl_q[AMTW-1].msb, amt_q[AMTW-1]};

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus randomized traffic
// against a queue-based arithmetic reference model.
module tb_shift_unit;

  localparam int unsigned W    = 32;
  localparam int unsigned TAGW = 4;
  localparam int unsigned AMTW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [AMTW-1:0] in_amt;
  logic [1:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_zero;
  logic [TAGW-1:0] out_tag;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(W), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [W-1:0]    data;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t            exp_q[$];
  int              errors  = 0;
  int              checks  = 0;
  int              acc_cnt = 0;
  int              out_cnt = 0;
  logic            last_acc = 1'b0;
  logic            obs_ov, obs_ir, obs_zero;
  logic [W-1:0]    obs_data;
  logic [TAGW-1:0] obs_tag;
  logic            hold_v = 1'b0;
  logic [W-1:0]    hold_data;
  logic [TAGW-1:0] hold_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic shifts on the whole operand.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] d, input int a);
    logic signed [W-1:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return sd >>> a;
      default: return (a == 0) ? d : ((d >> a) | (d << (W - a)));
    endcase
  endfunction

  // One clock: observe at negedge, score handshakes, advance past posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    obs_ov   = out_valid;
    obs_ir   = in_ready;
    obs_data = out_data;
    obs_zero = out_zero;
    obs_tag  = out_tag;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e.data = ref_shift(in_op, in_data, int'(in_amt));
      e.tag  = in_tag;
      exp_q.push_back(e);
      acc_cnt++;
    end
    if (hold_v) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data", 64'(out_data), 64'(hold_data));
      check("stall_tag", 64'(out_tag), 64'(hold_tag));
    end
    hold_v = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        check("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          check("out_zero", 64'(out_zero), 64'(e.data == '0));
        end
        out_cnt++;
      end else begin
        hold_v    = 1'b1;
        hold_data = out_data;
        hold_tag  = out_tag;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    in_op   = 2'($urandom_range(0, 3));
    in_data = W'($urandom());
    in_amt  = ($urandom_range(0, 7) == 0) ? '0 : AMTW'($urandom_range(0, W - 1));
    in_tag  = TAGW'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    cycle();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // Single request into an idle pipe; measures latency and returns the result.
  task automatic single(input logic [1:0] op, input logic [W-1:0] d, input logic [AMTW-1:0] a,
                        input logic [TAGW-1:0] t, output logic [W-1:0] res, output logic z,
                        output logic [TAGW-1:0] rt);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_amt    = a;
    in_tag    = t;
    cycle();
    check("single_accept", 64'(last_acc), 64'(1));
    in_valid = 1'b0;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!obs_ov && lat < 40);
    check("latency", 64'(lat), 64'(AMTW));
    res = obs_data;
    z   = obs_zero;
    rt  = obs_tag;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]    res;
    logic            z;
    logic [TAGW-1:0] rt;
    logic [W-1:0]    d;
    int              base, sent, c;
    bit              pat[4];

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Directed values
    single(2'b00, 32'h0000_00FF, 5'd4, 4'd3, res, z, rt);
    check("sll_ff_4", 64'(res), 64'h0000_0FF0);
    check("sll_ff_4_tag", 64'(rt), 64'd3);
    check("sll_ff_4_zero", 64'(z), 64'd0);
    single(2'b10, 32'h8000_0000, 5'd31, 4'd1, res, z, rt);
    check("sra_msb_31", 64'(res), 64'hFFFF_FFFF);
    single(2'b01, 32'h8000_0000, 5'd31, 4'd2, res, z, rt);
    check("srl_msb_31", 64'(res), 64'h0000_0001);
    single(2'b11, 32'h0000_0001, 5'd1, 4'd4, res, z, rt);
    check("ror_1_1", 64'(res), 64'h8000_0000);
    single(2'b00, 32'h8000_0000, 5'd1, 4'd5, res, z, rt);
    check("sll_to_zero", 64'(res), 64'd0);
    check("sll_to_zero_flag", 64'(z), 64'd1);
    for (int op = 0; op < 4; op++) begin
      d = W'($urandom()) | 32'h8000_0000;
      single(2'(op), d, '0, TAGW'(op), res, z, rt);
      check("amt0_identity", 64'(res), 64'(d));
    end

    // Back-to-back tags 0..7 with out_ready pattern 1,0,0,1
    base = out_cnt; sent = 0; c = 0;
    rand_payload(); in_tag = '0; in_valid = 1'b1;
    while ((sent < 8 || out_cnt - base < 8) && c < 200) begin
      out_ready = pat[c % 4];
      cycle();
      if (last_acc) begin
        sent++;
        if (sent < 8) begin
          rand_payload();
          in_tag = TAGW'(sent);
        end else begin
          in_valid = 1'b0;
        end
      end
      c++;
    end
    check("b2b_count", 64'(out_cnt - base), 64'd8);
    drain();

    // Continuous requests with out_ready low fill exactly AMTW stages
    out_ready = 1'b0; base = acc_cnt;
    rand_payload(); in_valid = 1'b1;
    repeat (3 * AMTW) begin
      cycle();
      if (last_acc) rand_payload();
    end
    check("fill_accepts", 64'(acc_cnt - base), 64'(AMTW));
    check("full_not_ready", 64'(obs_ir), 64'd0);
    out_ready = 1'b1;
    cycle();
    check("ready_after_release", 64'(obs_ir), 64'd1);
    drain();

    // Randomized traffic
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_payload();
      end
      cycle();
    end
    drain();

    // Reset with three requests in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    single(2'b10, 32'hF000_0000, 5'd4, 4'd9, res, z, rt);
    check("post_rst_sra", 64'(res), 64'hFF00_0000);
    check("post_rst_tag", 64'(rt), 64'd9);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
